// File: rtl/team_06_sram_wb_master.sv
// SRAM request to Wishbone classic-cycle master with one-deep pending slot.
// Ports: write/readEdge/addressIn/busAudioWrite/select in; busySRAM,
// busAudioRead, timeoutErr, overrun and the wb_* master bus out.
module team_06_sram_wb_master #(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned ADDR_W         = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              write,
  input  logic              readEdge,
  input  logic [ADDR_W-1:0] addressIn,
  input  logic [31:0]       busAudioWrite,
  input  logic [3:0]        select,
  output logic              busySRAM,
  output logic [31:0]       busAudioRead,
  output logic              timeoutErr,
  output logic              overrun,
  output logic              wb_cyc_o,
  output logic              wb_stb_o,
  output logic              wb_we_o,
  output logic [ADDR_W-1:0] wb_adr_o,
  output logic [31:0]       wb_dat_o,
  output logic [3:0]        wb_sel_o,
  input  logic [31:0]       wb_dat_i,
  input  logic              wb_ack_i
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DONE
  } state_t;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:2] adr;
    logic [31:0]       dat;
    logic [3:0]        sel;
  } req_t;

  state_t  state_q, state_d;
  logic    write_old_q;
  logic    pend_v_q, pend_v_d;
  req_t    pend_q, pend_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic              cyc_d, stb_d, we_d, busy_d;
  logic              to_d, ovr_d;
  logic [ADDR_W-1:0] adr_d;
  logic [31:0]       dat_d, rd_d;
  logic [3:0]        sel_d;

  logic wr_req, rd_req;
  logic unused_adr_lsb;

  assign wr_req = write & ~write_old_q;
  assign rd_req = readEdge;
  assign unused_adr_lsb = ^addressIn[1:0];

  function automatic req_t mk_req(input logic we);
    req_t r;
    r.we  = we;
    r.adr = addressIn[ADDR_W-1:2];
    r.dat = busAudioWrite;
    r.sel = select;
    return r;
  endfunction

  // Candidates in service order: pending entry, new write, new read.
  req_t       cand [3];
  logic [2:0] cand_v;
  req_t       first, second;
  logic       first_v, second_v, third_v;

  always_comb begin
    cand[0]  = pend_q;
    cand[1]  = mk_req(1'b1);
    cand[2]  = mk_req(1'b0);
    cand_v   = {rd_req, wr_req, pend_v_q};
    first    = '0;
    second   = '0;
    first_v  = 1'b0;
    second_v = 1'b0;
    third_v  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (cand_v[i]) begin
        if (!first_v) begin
          first   = cand[i];
          first_v = 1'b1;
        end else if (!second_v) begin
          second   = cand[i];
          second_v = 1'b1;
        end else begin
          third_v = 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    pend_v_d = pend_v_q;
    pend_d   = pend_q;
    cnt_d    = cnt_q;
    cyc_d    = wb_cyc_o;
    stb_d    = wb_stb_o;
    we_d     = wb_we_o;
    adr_d    = wb_adr_o;
    dat_d    = wb_dat_o;
    sel_d    = wb_sel_o;
    busy_d   = busySRAM;
    rd_d     = busAudioRead;
    to_d     = timeoutErr;
    ovr_d    = overrun;

    // In IDLE the first candidate goes on the bus and the second is
    // parked; elsewhere the first candidate is parked (the pending
    // entry keeps its place) and anything beyond is dropped.
    if (state_q == IDLE) begin
      pend_v_d = second_v;
      pend_d   = second_v ? second : pend_q;
      if (third_v) ovr_d = 1'b1;
    end else begin
      pend_v_d = first_v;
      pend_d   = first_v ? first : pend_q;
      if (second_v) ovr_d = 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        if (first_v) begin
          state_d = REQ;
          cyc_d   = 1'b1;
          stb_d   = 1'b1;
          we_d    = first.we;
          adr_d   = {first.adr, 2'b00};
          dat_d   = first.dat;
          sel_d   = first.sel;
          busy_d  = 1'b1;
          cnt_d   = '0;
        end
      end
      REQ: begin
        cnt_d = cnt_q + 1'b1;
        if (wb_ack_i) begin
          state_d = DONE;
          cyc_d   = 1'b0;
          stb_d   = 1'b0;
          we_d    = 1'b0;
          busy_d  = 1'b0;
          to_d    = 1'b0;
          if (!wb_we_o) rd_d = wb_dat_i;
        end else if (cnt_q == CNT_LAST) begin
          state_d = DONE;
          cyc_d   = 1'b0;
          stb_d   = 1'b0;
          we_d    = 1'b0;
          busy_d  = 1'b0;
          to_d    = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      write_old_q  <= 1'b0;
      pend_v_q     <= 1'b0;
      pend_q       <= '0;
      cnt_q        <= '0;
      wb_cyc_o     <= 1'b0;
      wb_stb_o     <= 1'b0;
      wb_we_o      <= 1'b0;
      wb_adr_o     <= '0;
      wb_dat_o     <= '0;
      wb_sel_o     <= '0;
      busySRAM     <= 1'b0;
      busAudioRead <= '0;
      timeoutErr   <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      state_q      <= state_d;
      write_old_q  <= write;
      pend_v_q     <= pend_v_d;
      pend_q       <= pend_d;
      cnt_q        <= cnt_d;
      wb_cyc_o     <= cyc_d;
      wb_stb_o     <= stb_d;
      wb_we_o      <= we_d;
      wb_adr_o     <= adr_d;
      wb_dat_o     <= dat_d;
      wb_sel_o     <= sel_d;
      busySRAM     <= busy_d;
      busAudioRead <= rd_d;
      timeoutErr   <= to_d;
      overrun      <= ovr_d;
    end
  end

endmodule

// File: tb/tb_team_06_sram_wb_master.sv
// Directed bench for team_06_sram_wb_master (TIMEOUT_CYCLES=4).
// Vector table of single transactions plus arbitration/reset sequences.
module tb_team_06_sram_wb_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        write, readEdge;
  logic [31:0] addressIn, busAudioWrite;
  logic [3:0]  select;
  logic        busySRAM, timeoutErr, overrun;
  logic [31:0] busAudioRead;
  logic        wb_cyc_o, wb_stb_o, wb_we_o;
  logic [31:0] wb_adr_o, wb_dat_o, wb_dat_i;
  logic [3:0]  wb_sel_o;
  logic        wb_ack_i;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  team_06_sram_wb_master #(
    .TIMEOUT_CYCLES(4),
    .ADDR_W(32)
  ) dut (
    .clk(clk),
    .rst(rst),
    .write(write),
    .readEdge(readEdge),
    .addressIn(addressIn),
    .busAudioWrite(busAudioWrite),
    .select(select),
    .busySRAM(busySRAM),
    .busAudioRead(busAudioRead),
    .timeoutErr(timeoutErr),
    .overrun(overrun),
    .wb_cyc_o(wb_cyc_o),
    .wb_stb_o(wb_stb_o),
    .wb_we_o(wb_we_o),
    .wb_adr_o(wb_adr_o),
    .wb_dat_o(wb_dat_o),
    .wb_sel_o(wb_sel_o),
    .wb_dat_i(wb_dat_i),
    .wb_ack_i(wb_ack_i)
  );

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] flags();
    return {26'd0, busySRAM, timeoutErr, overrun,
            wb_cyc_o, wb_stb_o, wb_we_o};
  endfunction

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] wdat;
    logic [3:0]  sel;
    int          k;
    logic [31:0] rdat;
    logic [31:0] exp_adr;
    logic [31:0] exp_rd;
    logic        exp_to;
  } vec_t;

  vec_t vt [7];

  initial begin
    int hi;

    // k = cycle offset of ACK after the request; 0 means no ACK.
    vt[0] = '{1'b1, 32'h33000010, 32'hA1B2C3D4, 4'hF, 2,
              32'hFFFFFFFF, 32'h33000010, 32'h00000000, 1'b0};
    vt[1] = '{1'b0, 32'h33000007, 32'h00000000, 4'hF, 1,
              32'h11223344, 32'h33000004, 32'h11223344, 1'b0};
    vt[2] = '{1'b0, 32'h00000100, 32'h00000000, 4'hF, 0,
              32'h99999999, 32'h00000100, 32'h11223344, 1'b1};
    vt[3] = '{1'b0, 32'h00000106, 32'h00000000, 4'h1, 3,
              32'hDEADBEEF, 32'h00000104, 32'hDEADBEEF, 1'b0};
    vt[4] = '{1'b1, 32'h0000000B, 32'h55AA55AA, 4'h3, 1,
              32'hFFFFFFFF, 32'h00000008, 32'hDEADBEEF, 1'b0};
    vt[5] = '{1'b1, 32'h00000020, 32'h01020304, 4'hC, 0,
              32'h88888888, 32'h00000020, 32'hDEADBEEF, 1'b1};
    vt[6] = '{1'b0, 32'h7FFFFFFD, 32'h00000000, 4'hF, 4,
              32'hCAFEF00D, 32'h7FFFFFFC, 32'hCAFEF00D, 1'b0};

    rst           = 1'b1;
    write         = 1'b0;
    readEdge      = 1'b0;
    addressIn     = '0;
    busAudioWrite = '0;
    select        = '0;
    wb_dat_i      = '0;
    wb_ack_i      = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("reset_flags", flags(), 32'd0);
    chk("reset_adr", wb_adr_o, 32'd0);
    chk("reset_dat", wb_dat_o, 32'd0);
    chk("reset_sel", {28'd0, wb_sel_o}, 32'd0);
    chk("reset_rd", busAudioRead, 32'd0);

    for (int i = 0; i < 7; i++) begin
      addressIn     = vt[i].adr;
      busAudioWrite = vt[i].wdat;
      select        = vt[i].sel;
      write         = vt[i].we;
      readEdge      = ~vt[i].we;
      tick();
      write    = 1'b0;
      readEdge = 1'b0;
      chk($sformatf("v%0d_cyc", i), {31'd0, wb_cyc_o}, 32'd1);
      chk($sformatf("v%0d_stb", i), {31'd0, wb_stb_o}, 32'd1);
      chk($sformatf("v%0d_we", i), {31'd0, wb_we_o}, {31'd0, vt[i].we});
      chk($sformatf("v%0d_adr", i), wb_adr_o, vt[i].exp_adr);
      chk($sformatf("v%0d_sel", i), {28'd0, wb_sel_o}, {28'd0, vt[i].sel});
      chk($sformatf("v%0d_busy", i), {31'd0, busySRAM}, 32'd1);
      if (vt[i].we)
        chk($sformatf("v%0d_dat", i), wb_dat_o, vt[i].wdat);
      if (vt[i].k > 0) begin
        repeat (vt[i].k - 1) tick();
        chk($sformatf("v%0d_busy_hold", i), {31'd0, busySRAM}, 32'd1);
        wb_ack_i = 1'b1;
        wb_dat_i = vt[i].rdat;
        tick();
        wb_ack_i = 1'b0;
      end else begin
        wb_dat_i = vt[i].rdat;
        repeat (3) tick();
        chk($sformatf("v%0d_cyc_last", i), {31'd0, wb_cyc_o}, 32'd1);
        tick();
      end
      chk($sformatf("v%0d_end_cyc", i), {31'd0, wb_cyc_o}, 32'd0);
      chk($sformatf("v%0d_end_busy", i), {31'd0, busySRAM}, 32'd0);
      chk($sformatf("v%0d_rd", i), busAudioRead, vt[i].exp_rd);
      chk($sformatf("v%0d_to", i), {31'd0, timeoutErr},
          {31'd0, vt[i].exp_to});
      if (vt[i].we)
        chk($sformatf("v%0d_dat_hold", i), wb_dat_o, vt[i].wdat);
      tick();
    end

    // Simultaneous write rise and read pulse.
    addressIn     = 32'h00000044;
    busAudioWrite = 32'h12345678;
    select        = 4'hF;
    write         = 1'b1;
    readEdge      = 1'b1;
    tick();
    write     = 1'b0;
    readEdge  = 1'b0;
    addressIn = 32'h00000F00;
    chk("sim_we_first", {31'd0, wb_we_o}, 32'd1);
    chk("sim_adr_w", wb_adr_o, 32'h00000044);
    wb_ack_i = 1'b1;
    tick();
    wb_ack_i = 1'b0;
    chk("sim_busy_fall", {31'd0, busySRAM}, 32'd0);
    tick();
    chk("sim_gap_cyc", {31'd0, wb_cyc_o}, 32'd0);
    tick();
    chk("sim_rd_cyc", {31'd0, wb_cyc_o}, 32'd1);
    chk("sim_rd_we", {31'd0, wb_we_o}, 32'd0);
    chk("sim_rd_adr", wb_adr_o, 32'h00000044);
    wb_ack_i = 1'b1;
    wb_dat_i = 32'h0BADCAFE;
    tick();
    wb_ack_i = 1'b0;
    chk("sim_rd_data", busAudioRead, 32'h0BADCAFE);
    chk("sim_overrun", {31'd0, overrun}, 32'd0);
    tick();

    // Overrun: active write, pending read, third request dropped.
    addressIn = 32'h00000100;
    write     = 1'b1;
    tick();
    write     = 1'b0;
    readEdge  = 1'b1;
    addressIn = 32'h00000200;
    tick();
    addressIn = 32'h00000300;
    tick();
    readEdge = 1'b0;
    chk("ovr_set", {31'd0, overrun}, 32'd1);
    chk("ovr_adr_w", wb_adr_o, 32'h00000100);
    wb_ack_i = 1'b1;
    tick();
    wb_ack_i = 1'b0;
    tick();
    tick();
    chk("ovr_pend_cyc", {31'd0, wb_cyc_o}, 32'd1);
    chk("ovr_pend_adr", wb_adr_o, 32'h00000200);
    wb_ack_i = 1'b1;
    wb_dat_i = 32'h00000077;
    tick();
    wb_ack_i = 1'b0;
    chk("ovr_pend_rd", busAudioRead, 32'h00000077);
    hi = 0;
    repeat (8) begin
      tick();
      if (wb_cyc_o) hi++;
    end
    chk("ovr_no_third", hi, 32'd0);
    chk("ovr_sticky", {31'd0, overrun}, 32'd1);

    // Asynchronous reset mid-REQ with an entry pending.
    addressIn = 32'h00000500;
    write     = 1'b1;
    tick();
    write    = 1'b0;
    readEdge = 1'b1;
    tick();
    readEdge = 1'b0;
    chk("rst_pre_cyc", {31'd0, wb_cyc_o}, 32'd1);
    #3 rst = 1'b1;
    #1;
    chk("rst_async_flags", flags(), 32'd0);
    chk("rst_async_adr", wb_adr_o, 32'd0);
    chk("rst_async_rd", busAudioRead, 32'd0);
    #2 rst = 1'b0;
    hi = 0;
    repeat (8) begin
      tick();
      if (wb_cyc_o) hi++;
    end
    chk("rst_no_cycle", hi, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
